// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int REG_ZERO       = 0;

   function automatic int num_regs(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, issue marks, writeback clears.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter bit ZERO_REG   = 1'b1
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            issue_en,
   input  logic [ADDR_WIDTH-1:0]           issue_addr,
   input  logic                            wr_en,
   input  logic [ADDR_WIDTH-1:0]           wr_addr,
   input  logic [ADDR_WIDTH-1:0]           rs_addr,
   input  logic [ADDR_WIDTH-1:0]           rt_addr,
   output logic                            rs_pend,
   output logic                            rt_pend,
   output logic [num_regs(ADDR_WIDTH)-1:0] busy_vec
);

   localparam int                    NUM_REGS  = num_regs(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic                w_rs_wr_hit;
   logic                w_rt_wr_hit;

   // Issue is applied after the clear so a new producer stays pending.
   always_comb begin
      w_busy_nxt = r_busy;
      if (wr_en)
         w_busy_nxt[wr_addr] = 1'b0;
      if (issue_en)
         w_busy_nxt[issue_addr] = 1'b1;
      if (ZERO_REG)
         w_busy_nxt[ZERO_ADDR] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   // A writeback landing this cycle resolves the hazard through the bypass.
   assign w_rs_wr_hit = wr_en && (wr_addr == rs_addr);
   assign w_rt_wr_hit = wr_en && (wr_addr == rt_addr);

   assign rs_pend  = r_busy[rs_addr] && !w_rs_wr_hit;
   assign rt_pend  = r_busy[rt_addr] && !w_rt_wr_hit;
   assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write bypass, registered read data
// and a scoreboard that stalls reads of registers awaiting long-latency results.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter bit ZERO_REG   = 1'b1
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            rd_en,
   input  logic [ADDR_WIDTH-1:0]           rs_addr,
   input  logic [ADDR_WIDTH-1:0]           rt_addr,
   output logic [DATA_WIDTH-1:0]           rs_data,
   output logic [DATA_WIDTH-1:0]           rt_data,
   output logic                            rd_valid,
   output logic                            stall,
   input  logic                            wr_en,
   input  logic [ADDR_WIDTH-1:0]           wr_addr,
   input  logic [DATA_WIDTH-1:0]           wr_data,
   input  logic                            issue_en,
   input  logic [ADDR_WIDTH-1:0]           issue_addr,
   output logic [num_regs(ADDR_WIDTH)-1:0] busy_vec
);

   localparam int                    NUM_REGS  = num_regs(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
   logic [DATA_WIDTH-1:0] r_rs_data;
   logic [DATA_WIDTH-1:0] r_rt_data;
   logic                  r_rd_valid;

   logic [DATA_WIDTH-1:0] w_rs_eff;
   logic [DATA_WIDTH-1:0] w_rt_eff;
   logic                  w_rs_pend;
   logic                  w_rt_pend;
   logic                  w_stall;
   logic                  w_accept;
   logic                  w_wr_ok;

   regfile_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
   ) u_scoreboard (
      .clock      (clock),
      .reset_n    (reset_n),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rs_pend    (w_rs_pend),
      .rt_pend    (w_rt_pend),
      .busy_vec   (busy_vec)
   );

   assign w_wr_ok  = wr_en && !(ZERO_REG && (wr_addr == ZERO_ADDR));
   assign w_stall  = rd_en && (w_rs_pend || w_rt_pend);
   assign w_accept = rd_en && !w_stall;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_regs[i] <= '0;
      end else if (w_wr_ok) begin
         r_regs[wr_addr] <= wr_data;
      end
   end

   // Zero-register override sits last so it also beats the bypass.
   always_comb begin
      w_rs_eff = r_regs[rs_addr];
      if (wr_en && (wr_addr == rs_addr))
         w_rs_eff = wr_data;
      if (ZERO_REG && (rs_addr == ZERO_ADDR))
         w_rs_eff = '0;
   end

   always_comb begin
      w_rt_eff = r_regs[rt_addr];
      if (wr_en && (wr_addr == rt_addr))
         w_rt_eff = wr_data;
      if (ZERO_REG && (rt_addr == ZERO_ADDR))
         w_rt_eff = '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rs_data  <= '0;
         r_rt_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_accept;
         if (w_accept) begin
            r_rs_data <= w_rs_eff;
            r_rt_data <= w_rt_eff;
         end
      end
   end

   assign rs_data  = r_rs_data;
   assign rt_data  = r_rt_data;
   assign rd_valid = r_rd_valid;
   assign stall    = w_stall;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed plan steps plus randomized traffic against a reference model.
module tb_regfile_sb;

   logic        clock;
   logic        reset_n;
   logic        rd_en;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [63:0] rs_data;
   logic [63:0] rt_data;
   logic        rd_valid;
   logic        stall;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic        issue_en;
   logic [4:0]  issue_addr;
   logic [31:0] busy_vec;

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0] m_regs [32];
   bit          m_busy [32];
   logic [63:0] m_rs;
   logic [63:0] m_rt;
   bit          m_vld;

   regfile_sb #(
      .DATA_WIDTH (64),
      .ADDR_WIDTH (5),
      .ZERO_REG   (1'b1)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .rd_en      (rd_en),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .rd_valid   (rd_valid),
      .stall      (stall),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .busy_vec   (busy_vec)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_busy_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++)
         v[i] = m_busy[i];
      return v;
   endfunction

   function automatic logic [63:0] m_read(input int a, input bit we, input int wa,
                                          input logic [63:0] wd);
      if (a == 0)
         return 64'd0;
      if (we && wa == a)
         return wd;
      return m_regs[a];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 64'd0;
         m_busy[i] = 1'b0;
      end
      m_rs  = 64'd0;
      m_rt  = 64'd0;
      m_vld = 1'b0;
   endtask

   // One clock of stimulus; stall is checked before the edge, state after it.
   task automatic cycle(input bit rd, input int rs, input int rt, input bit we,
                        input int wa, input logic [63:0] wd, input bit ie, input int ia);
      bit          p_rs;
      bit          p_rt;
      bit          e_stall;
      logic [63:0] e_rs;
      logic [63:0] e_rt;
      @(negedge clock);
      rd_en      = rd;
      rs_addr    = 5'(rs);
      rt_addr    = 5'(rt);
      wr_en      = we;
      wr_addr    = 5'(wa);
      wr_data    = wd;
      issue_en   = ie;
      issue_addr = 5'(ia);
      p_rs    = m_busy[rs] && !(we && wa == rs);
      p_rt    = m_busy[rt] && !(we && wa == rt);
      e_stall = rd && (p_rs || p_rt);
      e_rs    = m_read(rs, we, wa, wd);
      e_rt    = m_read(rt, we, wa, wd);
      #1;
      check_val("stall", {63'd0, stall}, {63'd0, e_stall});
      if (rd && !e_stall) begin
         m_rs  = e_rs;
         m_rt  = e_rt;
         m_vld = 1'b1;
      end else begin
         m_vld = 1'b0;
      end
      if (we && wa != 0)
         m_regs[wa] = wd;
      if (we)
         m_busy[wa] = 1'b0;
      if (ie && ia != 0)
         m_busy[ia] = 1'b1;
      @(posedge clock);
      #1;
      check_val("rd_valid", {63'd0, rd_valid}, {63'd0, m_vld});
      check_val("rs_data", rs_data, m_rs);
      check_val("rt_data", rt_data, m_rt);
      check_val("busy_vec", {32'd0, busy_vec}, {32'd0, m_busy_vec()});
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 64'd0, 0, 0);
   endtask

   initial begin
      reset_n    = 1'b0;
      rd_en      = 1'b0;
      rs_addr    = '0;
      rt_addr    = '0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      issue_en   = 1'b0;
      issue_addr = '0;
      m_reset();
      #12;
      check_val("rst_rs_data", rs_data, 64'd0);
      check_val("rst_rt_data", rt_data, 64'd0);
      check_val("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
      check_val("rst_busy_vec", {32'd0, busy_vec}, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Plan 1: read after reset.
      cycle(1, 3, 4, 0, 0, 64'd0, 0, 0);
      check_val("p1_valid", {63'd0, rd_valid}, 64'd1);
      check_val("p1_rs", rs_data, 64'd0);

      // Plan 2: write then read.
      cycle(0, 0, 0, 1, 5, 64'h1234, 0, 0);
      cycle(1, 5, 5, 0, 0, 64'd0, 0, 0);
      check_val("p2_rs", rs_data, 64'h1234);
      check_val("p2_rt_same_addr", rt_data, 64'h1234);

      // Plan 3: bypass.
      cycle(1, 7, 5, 1, 7, 64'hDEAD, 0, 0);
      check_val("p3_bypass", rs_data, 64'hDEAD);

      // Plan 4: stall on pending register, released by writeback.
      cycle(0, 0, 0, 0, 0, 64'd0, 1, 9);
      idle();
      cycle(1, 9, 5, 0, 0, 64'd0, 0, 0);
      check_val("p4_stall_valid", {63'd0, rd_valid}, 64'd0);
      check_val("p4_held", rs_data, 64'hDEAD);
      cycle(1, 9, 5, 1, 9, 64'h55, 0, 0);
      check_val("p4_release", rs_data, 64'h55);
      check_val("p4_busy9", {63'd0, busy_vec[9]}, 64'd0);

      // Plan 5: zero register ignores write and issue.
      cycle(0, 0, 0, 1, 0, 64'hFF, 1, 0);
      cycle(1, 0, 0, 0, 0, 64'd0, 0, 0);
      check_val("p5_zero", rs_data, 64'd0);
      check_val("p5_busy0", {63'd0, busy_vec[0]}, 64'd0);

      // Read in the same cycle as an issue to its source sees the old busy bit.
      cycle(1, 6, 6, 0, 0, 64'd0, 1, 6);
      check_val("same_cyc_issue_valid", {63'd0, rd_valid}, 64'd1);
      cycle(0, 0, 0, 1, 6, 64'h66, 0, 0);

      // Plan 6: issue wins over simultaneous write.
      cycle(0, 0, 0, 1, 12, 64'h1, 1, 12);
      check_val("p6_busy12", {63'd0, busy_vec[12]}, 64'd1);
      check_val("p6_reg12", dut.r_regs[12], 64'h1);

      // Reset asserted mid-stall.
      @(negedge clock);
      rd_en   = 1'b1;
      rs_addr = 5'd12;
      rt_addr = 5'd12;
      wr_en   = 1'b0;
      issue_en = 1'b0;
      #1;
      check_val("pre_rst_stall", {63'd0, stall}, 64'd1);
      reset_n = 1'b0;
      #1;
      m_reset();
      check_val("mid_rst_rs", rs_data, 64'd0);
      check_val("mid_rst_rt", rt_data, 64'd0);
      check_val("mid_rst_valid", {63'd0, rd_valid}, 64'd0);
      check_val("mid_rst_busy", {32'd0, busy_vec}, 64'd0);
      check_val("mid_rst_stall", {63'd0, stall}, 64'd0);
      @(negedge clock);
      rd_en   = 1'b0;
      reset_n = 1'b1;

      // Randomized traffic over a narrow address window to force collisions.
      for (int n = 0; n < 2000; n++) begin
         cycle($urandom_range(0, 99) < 60,
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               $urandom_range(0, 99) < 65, int'($urandom_range(0, 7)),
               {$urandom, $urandom},
               $urandom_range(0, 99) < 25, int'($urandom_range(0, 7)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
